// File: rtl/mux_mult_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_mult_serial_ctrl
// Brief    : Digit-serial WIDTHxWIDTH unsigned multiplier built around a 2x2
//            mux-based multiplier cell. Optional macro: MUX_MULT_ZERO_SKIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux_mult_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int D     = WIDTH / 2;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]     i_q, i_d;
    logic [IDX_W-1:0]     j_q, j_d;

    logic [1:0]           x_digit;
    logic [1:0]           y_digit;
    logic [3:0]           pp;
    logic [2*WIDTH-1:0]   pp_ext;

    // 2x2 cell: each multiplier bit gates a shifted copy of the multiplicand digit
    always_comb begin
        x_digit = a_q[2*int'(i_q) +: 2];
        y_digit = b_q[2*int'(j_q) +: 2];
        pp      = (y_digit[0] ? {2'b00, x_digit}       : 4'd0)
                + (y_digit[1] ? {1'b0, x_digit, 1'b0}  : 4'd0);
        pp_ext       = '0;
        pp_ext[3:0]  = pp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RUN;
`ifdef MUX_MULT_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = acc_q + (pp_ext << (2 * (int'(i_q) + int'(j_q))));
                if (j_q == C_LAST) begin
                    j_d = '0;
                    i_d = i_q + IDX_W'(1);
                    if (i_q == C_LAST) begin
                        state_d = S_DONE;
                    end
                end else begin
                    j_d = j_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Product is gated so a partially accumulated value never leaves the block
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign product   = (state_q == S_DONE) ? acc_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mux_mult_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_mult_serial_ctrl
// Brief    : Scoreboard bench for mux_mult_serial_ctrl with random operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_mult_serial_ctrl;

    localparam int WIDTH = 8;
    localparam int D     = WIDTH / 2;
    localparam int RUNC  = D * D;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    mux_mult_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*WIDTH-1:0] exp;
        int                 acc_cyc;
        int                 lat;
    } op_t;

    op_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef MUX_MULT_ZERO_SKIP_EN
        if (x == 0 || y == 0) return 1;
`endif
        return RUNC + 1;
    endfunction

    // Monitor: per-cycle handshake/busy expectations and scoreboard pops
    initial begin
        logic               prev_v;
        logic [2*WIDTH-1:0] held;
        int                 d;
        logic               exp_busy;
        op_t                op;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
                continue;
            end
            exp_busy = 1'b0;
            if (sb.size() > 0) begin
                d = cyc - sb[0].acc_cyc;
                exp_busy = (sb[0].lat > 1) && (d >= 1) && (d <= RUNC);
                check("out_valid", 64'(out_valid), 64'(d >= sb[0].lat));
            end else begin
                check("out_valid_idle", 64'(out_valid), 64'd0);
            end
            check("busy", 64'(busy), 64'(exp_busy));
            check("in_ready", 64'(in_ready), 64'(sb.size() == 0));
            if (out_valid) begin
                if (prev_v) check("hold", 64'(product), 64'(held));
                held = product;
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        op = sb.pop_front();
                        check("product", 64'(product), 64'(op.exp));
                    end
                end
            end
            prev_v = out_valid && !out_ready;
        end
    end

    // Random backpressure, only when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int  n;
        op_t op;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = x;
        b = y;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                check("accept_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        #1;
        op.exp     = (2*WIDTH)'(x) * (2*WIDTH)'(y);
        op.acc_cyc = cyc;
        op.lat     = exp_lat(x, y);
        sb.push_back(op);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                check("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", 64'(product), 64'd0);

        issue(8'd13, 8'd11);
        drain();
        issue(8'd255, 8'd255);
        drain();
        issue(8'd0, 8'd200);
        drain();
        issue(8'd200, 8'd0);
        drain();

        // Backpressure: hold the result for 10 cycles
        out_ready = 1'b0;
        issue(8'd7, 8'd9);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_product", 64'(product), 64'd63);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Operands presented during RUN must be ignored
        issue(8'd100, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 8'd5;
        b = 8'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset in the 8th RUN cycle aborts the operation
        issue(8'd100, 8'd200);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_product", 64'(product), 64'd0);
        issue(8'd2, 8'd3);
        drain();

        // Randomized operands with random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '1;
            issue(ra, rb);
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_mult_serial_ctrl.md
# mux_mult_serial_ctrl

Digit-serial controller that computes a WIDTH×WIDTH unsigned product by streaming 2-bit operand digit pairs through one instance of the team's 2×2 mux-based multiplier cell array. It shifts each 4-bit partial product into place and accumulates it into a 2·WIDTH result. The block sits directly upstream of the 2×2 multiplier: it feeds the multiplier's operand bits and consumes its product bits. It presents a valid/ready handshake to the datapath on both sides.

## Interface
- WIDTH, 8, operand width in bits; even, ≥ 2. D = WIDTH/2 digits per operand.

- clk  input  1  single clock, rising-edge
- reset  input  1  reset; synchronous and active-high
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2·WIDTH  a×b, unsigned
- busy  output  1  high in RUN

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: capture a and b, clear acc to 0, set digit indices i = 0, j = 0, go to RUN.
- **RUN**
  - The 2×2 multiplier receives {x1,x0} = a[2i+1:2i] and {y1,y0} = b[2j+1:2j].
  - Its result {p3..p0} is zero-extended to 2·WIDTH, shifted left by 2(i+j), and added to acc at the clock edge.
  - j increments each cycle. When j = D−1, j wraps to 0 and i increments.
  - After the pair i = j = D−1 is accumulated, go to DONE.
- **DONE**
  - out_valid = 1, product = acc.
  - On out_ready: go to IDLE.
- Inputs a, b and in_valid are ignored outside IDLE; in_ready = 0 in RUN and DONE.
- Arithmetic: the accumulator is 2·WIDTH bits and cannot overflow, since the maximum product is (2^WIDTH − 1)^2.
- in_ready, out_valid and busy are decoded combinationally from the state register only.

## Timing
- Reset values (state and all outputs):
  - state = IDLE, acc = 0, product = 0
  - out_valid = 0, busy = 0, in_ready = 1
- Reset asserted in any state (including mid-RUN or DONE):
  - The in-flight operation is aborted.
  - Next cycle the block is in IDLE with the reset values above.
  - No partial product is ever presented.
- Latency:
  - Accept occurs in cycle 0.
  - RUN occupies cycles 1..D².
  - out_valid rises in cycle D²+1.
  - For WIDTH = 8 this is 16 RUN cycles, with out_valid in cycle 17.
- Throughput: one product per D²+2 cycles when out_ready is held high. The DONE→IDLE transition costs one cycle; there is no accept in the same cycle as the output handshake.
- Backpressure: while out_valid && !out_ready, product and out_valid hold stable indefinitely.
- reset and in_valid in the same cycle: reset wins, and the operands are not captured.

## Configuration
- Macro: MUX_MULT_ZERO_SKIP_EN.
- Defined:
  - On accept, if a == 0 or b == 0, go directly from IDLE to DONE with acc = 0.
  - out_valid is then high in cycle 1 and busy never asserts.
  - Non-zero operands behave exactly as in the undefined case.
- Undefined:
  - Every accepted operation takes the full D² RUN cycles, including zero operands.
  - Latency is data-independent.

## Test plan
- WIDTH = 8, a = 13, b = 11, out_ready = 1 → busy for cycles 1–16; out_valid in cycle 17 with product = 143; in_ready back to 1 in cycle 18.
- a = 255, b = 255 → product = 65025 (0xFE01); checks full carry propagation through the top accumulator bits.
- a = 0, b = 200 → with MUX_MULT_ZERO_SKIP_EN: out_valid in cycle 1, product = 0. Without it: out_valid in cycle 17, product = 0.
- a = 7, b = 9, out_ready = 0 for 10 cycles after out_valid → product holds 63 and out_valid stays 1 throughout; one cycle after out_ready rises, the block is in IDLE.
- a = 100, b = 3 applied, then in_valid pulsed with a = 5, b = 5 during RUN → second operands ignored; product = 300.
- Reset asserted in cycle 8 of RUN → next cycle: out_valid = 0, busy = 0, in_ready = 1, product = 0. A new accept of a = 2, b = 3 then yields product = 6 in cycle 17.
